// File: rtl/sel_debouncer_if.sv
// Button-side signal bundle for sel_debouncer: raw button and clear in,
// debounced select level and event pulses out.
interface sel_debouncer_if;
  logic btn_i;
  logic clr_i;
  logic sel_o;
  logic press_o;
  logic release_o;
  logic long_o;

  modport master (
    output btn_i,
    output clr_i,
    input  sel_o,
    input  press_o,
    input  release_o,
    input  long_o
  );

  modport slave (
    input  btn_i,
    input  clr_i,
    output sel_o,
    output press_o,
    output release_o,
    output long_o
  );
endinterface

// File: rtl/sel_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, toggle level and
// press/release pulses. Long-press detection is built when SEL_DEBOUNCER_LONG_PRESS_EN is defined.
module sel_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  sel_debouncer_if.slave    bus
);

  localparam int CNT_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEB_HIGH = 2'd1,
    ST_HELD     = 2'd2,
    ST_DEB_LOW  = 2'd3
  } state_e;

  logic             sync1_q;
  logic             btn_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_fire_s;

`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 2);
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q;
`endif

  // Synchronizer, FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
      hold_q    <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= bus.btn_i;
      btn_s_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
      hold_q    <= hold_d;
      long_q    <= long_fire_s;
`endif
    end
  end

  // Next-state, counter and pulse decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_fire_s = 1'b0;
`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (btn_s_q) begin
          state_d = ST_DEB_HIGH;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEB_HIGH: begin
        if (!btn_s_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_MAX) begin
          state_d = ST_HELD;
          press_d = 1'b1;
`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
          hold_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HELD: begin
        if (!btn_s_q) begin
          state_d = ST_DEB_LOW;
          cnt_d   = '0;
        end else begin
          state_d = ST_HELD;
`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
          // Saturation stops the count, so the pulse can fire only once per press
          if (hold_q != LONG_MAX) begin
            hold_d      = hold_q + {{(CNT_W-1){1'b0}}, 1'b1};
            long_fire_s = (hold_q == LONG_PRE);
          end else begin
            hold_d = hold_q;
          end
`endif
        end
      end
      ST_DEB_LOW: begin
        if (btn_s_q) begin
          state_d = ST_HELD;
        end else if (cnt_q == DEB_MAX) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Select level: clear and long press both beat a same-cycle toggle
  always_comb begin
    sel_d = sel_q;
    if (bus.clr_i) begin
      sel_d = 1'b0;
    end else if (long_fire_s) begin
      sel_d = 1'b0;
    end else if (press_d) begin
      sel_d = ~sel_q;
    end else begin
      sel_d = sel_q;
    end
  end

  assign bus.sel_o     = sel_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;
`ifdef SEL_DEBOUNCER_LONG_PRESS_EN
  assign bus.long_o    = long_q;
`else
  assign bus.long_o    = 1'b0;
`endif

endmodule
